alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; SHALL be a power of two, at least 8.
REQ-002 Derived SHW = log2(WIDTH), shift-amount width; SHALL not be overridable.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept; transfer occurs when in_valid && in_ready at a rising edge.
REQ-007 exe_cmd  input  4  operation code.
REQ-008 input_val1, input_val2  input  WIDTH  operands.
REQ-009 out_valid  output  1  result registers hold a valid result.
REQ-010 out_ready  input  1  consumer accepts; result drains when out_valid && out_ready at a rising edge.
REQ-011 output_val  output  WIDTH  result.
REQ-012 flags  output  4  {N,Z,C,V} for output_val.

Function
REQ-013 Encodings SHALL be: 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR, 1000 SLL, 1001 SRA, 1010 SRL, 1100 MUL; any other code SHALL produce 0 with normal latency.
REQ-014 Shifts SHALL use input_val2[SHW-1:0] only; SRA SHALL replicate input_val1 MSB; arithmetic is modulo 2^WIDTH.
REQ-015 N SHALL be output_val MSB, Z SHALL be 1 iff output_val == 0, for all ops.
REQ-016 ADD: C = carry out, V = signed overflow; SUB: C = 1 iff input_val1 >= input_val2 unsigned (no borrow), V = signed overflow; C and V SHALL be 0 for all other ops.
REQ-017 Controller states SHALL be IDLE, MUL, DONE-hold implied by out_valid; in_ready = (state == IDLE) && (!out_valid || out_ready).
REQ-018 Non-MUL op accepted at edge k SHALL be in output_val/flags with out_valid = 1 after edge k (latency 1).
REQ-019 MUL accepted at edge k SHALL enter MUL, iterate one shift-add per cycle for WIDTH cycles, return to IDLE, and present the low WIDTH bits of the product with out_valid = 1 after edge k+WIDTH.
REQ-020 While in MUL, in_ready SHALL be 0; out_valid of a previous result MAY still drain.
REQ-021 output_val and flags SHALL remain stable while out_valid && !out_ready.
REQ-022 Simultaneous drain and accept in the same edge SHALL be lossless: new result replaces old, out_valid stays 1 (non-MUL) or falls to 0 (MUL).
REQ-023 out_valid SHALL fall after a drain edge with no new completing result.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, out_valid 0, output_val 0, flags 0, multiply iteration counter 0.
REQ-025 Reset mid-MUL SHALL discard the operation; after release in_ready SHALL be 1 in the first cycle.

Configuration
REQ-026 Macro ALU_PIPE_MUL_EN: defined, MUL (1100) behaves per REQ-019; undefined, the MUL state and multiplier logic SHALL be absent, 1100 SHALL behave as an undefined code (result 0, latency 1), and in_ready = !out_valid || out_ready.

Verification (WIDTH = 32)
REQ-027 ADD 0x7FFFFFFF + 0x00000001, out_ready = 1 -> next cycle 0x80000000, flags N=1 Z=0 C=0 V=1.
REQ-028 SUB 5 - 5 -> 0, Z=1 C=1; NOR 0x0F0F0F0F, 0xF0F0F0F0 -> 0, Z=1, C=V=0.
REQ-029 SRA 0x80000000 by input_val2 = 0x24 (amount 4) -> 0xF8000000, N=1; SRL same -> 0x08000000.
REQ-030 out_ready = 0, ADD 1+2 accepted, then a second request held 5 cycles -> in_ready 0, output_val stays 3; out_ready = 1 -> second accepted same edge, no result lost.
REQ-031 MUL_EN defined: MUL 7 x 6 -> out_valid exactly 32 cycles after accept, 42; MUL 0xFFFFFFFF x 2 -> 0xFFFFFFFE, C=V=0.
REQ-032 rst_n pulsed low 10 cycles into a MUL -> out_valid 0 immediately, in_ready 1 after release, next ADD 2+2 -> 4; MUL_EN undefined: MUL 7 x 6 -> 0, Z=1, latency 1.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with a valid/ready input, a one-entry result register and {N,Z,C,V} flags.
// Define ALU_PIPE_MUL_EN to add a WIDTH-cycle iterative shift-add multiplier on opcode 1100.
module alu_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       exe_cmd,
   input  logic [WIDTH-1:0] input_val1,
   input  logic [WIDTH-1:0] input_val2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] output_val,
   output logic [3:0]       flags
);
   localparam int SHW = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_NOR = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b0111;
   localparam logic [3:0] OP_SLL = 4'b1000;
   localparam logic [3:0] OP_SRA = 4'b1001;
   localparam logic [3:0] OP_SRL = 4'b1010;

   logic [WIDTH:0]   add_full;
   logic [WIDTH-1:0] sub_res;
   logic [WIDTH-1:0] alu_res;
   logic [SHW-1:0]   shamt;
   logic             alu_c;
   logic             alu_v;
   logic [3:0]       alu_flags;
   logic             accept;
   logic             drain;

   assign shamt    = input_val2[SHW-1:0];
   assign add_full = {1'b0, input_val1} + {1'b0, input_val2};
   assign sub_res  = input_val1 - input_val2;
   assign accept   = in_valid && in_ready;
   assign drain    = out_valid && out_ready;

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (exe_cmd)
         OP_ADD: begin
            alu_res = add_full[WIDTH-1:0];
            alu_c   = add_full[WIDTH];
            alu_v   = (input_val1[MSB] == input_val2[MSB]) && (alu_res[MSB] != input_val1[MSB]);
         end
         OP_SUB: begin
            // C is "no borrow", i.e. unsigned input_val1 >= input_val2
            alu_res = sub_res;
            alu_c   = input_val1 >= input_val2;
            alu_v   = (input_val1[MSB] != input_val2[MSB]) && (sub_res[MSB] != input_val1[MSB]);
         end
         OP_AND:  alu_res = input_val1 & input_val2;
         OP_OR:   alu_res = input_val1 | input_val2;
         OP_NOR:  alu_res = ~(input_val1 | input_val2);
         OP_XOR:  alu_res = input_val1 ^ input_val2;
         OP_SLL:  alu_res = input_val1 << shamt;
         OP_SRA:  alu_res = $signed(input_val1) >>> shamt;
         OP_SRL:  alu_res = input_val1 >> shamt;
         default: alu_res = '0;
      endcase
   end

   assign alu_flags = {alu_res[MSB], alu_res == '0, alu_c, alu_v};

`ifdef ALU_PIPE_MUL_EN
   localparam logic [3:0]     OP_MUL   = 4'b1100;
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   typedef enum logic {ST_IDLE, ST_MUL} state_t;

   state_t           state;
   logic [WIDTH-1:0] mul_cand;
   logic [WIDTH-1:0] mul_plier;
   logic [WIDTH-1:0] mul_acc;
   logic [WIDTH-1:0] mul_acc_next;
   logic [SHW-1:0]   mul_cnt;

   assign mul_acc_next = mul_plier[0] ? mul_acc + mul_cand : mul_acc;
   assign in_ready     = (state == ST_IDLE) && (!out_valid || out_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         out_valid  <= 1'b0;
         output_val <= '0;
         flags      <= '0;
         mul_cand   <= '0;
         mul_plier  <= '0;
         mul_acc    <= '0;
         mul_cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept && exe_cmd == OP_MUL) begin
                  // accept implies any held result drains on this same edge
                  state     <= ST_MUL;
                  out_valid <= 1'b0;
                  mul_cand  <= input_val1;
                  mul_plier <= input_val2;
                  mul_acc   <= '0;
                  mul_cnt   <= '0;
               end else if (accept) begin
                  out_valid  <= 1'b1;
                  output_val <= alu_res;
                  flags      <= alu_flags;
               end else if (drain) begin
                  out_valid <= 1'b0;
               end
            end
            ST_MUL: begin
               if (drain) out_valid <= 1'b0;
               mul_cand  <= mul_cand << 1;
               mul_plier <= mul_plier >> 1;
               mul_acc   <= mul_acc_next;
               mul_cnt   <= mul_cnt + 1'b1;
               if (mul_cnt == CNT_LAST) begin
                  state      <= ST_IDLE;
                  out_valid  <= 1'b1;
                  output_val <= mul_acc_next;
                  flags      <= {mul_acc_next[MSB], mul_acc_next == '0, 2'b00};
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
`else
   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         output_val <= '0;
         flags      <= '0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         output_val <= alu_res;
         flags      <= alu_flags;
      end else if (drain) begin
         out_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and random stimulus for alu_pipe (WIDTH=32), checked every cycle
// against a behavioural model built from the operation table and handshake rules.
module tb_alu_pipe;
   localparam int W = 32;
`ifdef ALU_PIPE_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [3:0]   exe_cmd = '0;
   logic [W-1:0] input_val1 = '0;
   logic [W-1:0] input_val2 = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] output_val;
   logic [3:0]   flags;

   int n_checks = 0;
   int n_fail = 0;

   // model: result register contents plus remaining cycles of an in-flight multiply
   bit           exp_valid = 1'b0;
   logic [W-1:0] exp_val = '0;
   logic [3:0]   exp_flags = '0;
   int           pend = 0;
   logic [W-1:0] mul_val = '0;
   logic [3:0]   mul_flags = '0;

   alu_pipe #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .exe_cmd    (exe_cmd),
      .input_val1 (input_val1),
      .input_val2 (input_val2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .output_val (output_val),
      .flags      (flags)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // returns {flags, result}
   function automatic logic [W+3:0] ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      logic [63:0]  u;
      longint       s;
      bit           c;
      bit           v;
      int           sh;
      r  = '0;
      c  = 1'b0;
      v  = 1'b0;
      sh = int'(b % W);
      case (op)
         4'b0000: begin
            u = 64'(a) + 64'(b);
            r = u[W-1:0];
            c = u[W];
            s = longint'($signed(a)) + longint'($signed(b));
            v = s != longint'($signed(r));
         end
         4'b0010: begin
            r = a - b;
            c = a >= b;
            s = longint'($signed(a)) - longint'($signed(b));
            v = s != longint'($signed(r));
         end
         4'b0100: r = a & b;
         4'b0101: r = a | b;
         4'b0110: r = ~(a | b);
         4'b0111: r = a ^ b;
         4'b1000: r = a << sh;
         4'b1001: r = $signed(a) >>> sh;
         4'b1010: r = a >> sh;
         4'b1100: begin
`ifdef ALU_PIPE_MUL_EN
            u = 64'(a) * 64'(b);
            r = u[W-1:0];
`else
            r = '0;
`endif
         end
         default: r = '0;
      endcase
      return {r[W-1], r == '0, c, v, r};
   endfunction

   // drive one cycle starting at a negedge, check outputs, advance the model over the next posedge
   task automatic drive_cycle(input bit v, input logic [3:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input bit ordy);
      bit           rdy;
      bit           acc;
      bit           drn;
      logic [W+3:0] rr;
      in_valid   = v;
      exe_cmd    = op;
      input_val1 = a;
      input_val2 = b;
      out_ready  = ordy;
      #1;
      rdy = (pend == 0) && (!exp_valid || ordy);
      check_eq("in_ready", in_ready, rdy);
      check_eq("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
         check_eq("output_val", output_val, exp_val);
         check_eq("flags", flags, exp_flags);
      end
      acc = v && rdy;
      drn = exp_valid && ordy;
      if (acc) $display("txn cmd=%b a=%h b=%h", op, a, b);
      if (pend > 0) begin
         if (drn) exp_valid = 1'b0;
         pend--;
         if (pend == 0) begin
            exp_valid = 1'b1;
            exp_val   = mul_val;
            exp_flags = mul_flags;
         end
      end else if (acc) begin
         rr = ref_op(op, a, b);
         if (MUL_EN && op == 4'b1100) begin
            pend      = W;
            mul_val   = rr[W-1:0];
            mul_flags = rr[W+3:W];
            exp_valid = 1'b0;
         end else begin
            exp_valid = 1'b1;
            exp_val   = rr[W-1:0];
            exp_flags = rr[W+3:W];
         end
      end else if (drn) begin
         exp_valid = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic apply_reset(input int cycles);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_output_val", output_val, '0);
      check_eq("rst_flags", flags, 4'b0000);
      exp_valid = 1'b0;
      exp_val   = '0;
      exp_flags = '0;
      pend      = 0;
      repeat (cycles) @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      @(negedge clk);
      apply_reset(3);

      drive_cycle(1'b1, 4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
      check_eq("add_ovf_val", output_val, 32'h8000_0000);
      check_eq("add_ovf_flags", flags, 4'b1001);
      drive_cycle(1'b1, 4'b0010, 32'd5, 32'd5, 1'b1);
      check_eq("sub_eq_val", output_val, 32'h0);
      check_eq("sub_eq_flags", flags, 4'b0110);
      drive_cycle(1'b1, 4'b0110, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1);
      check_eq("nor_val", output_val, 32'h0);
      check_eq("nor_flags", flags, 4'b0100);
      drive_cycle(1'b1, 4'b1001, 32'h8000_0000, 32'h0000_0024, 1'b1);
      check_eq("sra_val", output_val, 32'hF800_0000);
      check_eq("sra_flags", flags, 4'b1000);
      drive_cycle(1'b1, 4'b1010, 32'h8000_0000, 32'h0000_0024, 1'b1);
      check_eq("srl_val", output_val, 32'h0800_0000);
      check_eq("srl_flags", flags, 4'b0000);

      // backpressure: result held, second request stalls, then drains and accepts on one edge
      drive_cycle(1'b1, 4'b0000, 32'd1, 32'd2, 1'b1);
      repeat (5) begin
         drive_cycle(1'b1, 4'b0010, 32'd9, 32'd4, 1'b0);
         check_eq("hold_val", output_val, 32'd3);
      end
      drive_cycle(1'b1, 4'b0010, 32'd9, 32'd4, 1'b1);
      check_eq("swap_valid", out_valid, 1'b1);
      check_eq("swap_val", output_val, 32'd5);
      drive_cycle(1'b0, 4'b0000, '0, '0, 1'b1);

      drive_cycle(1'b1, 4'b1100, 32'd7, 32'd6, 1'b1);
`ifdef ALU_PIPE_MUL_EN
      repeat (W - 1) drive_cycle(1'b0, 4'b0000, '0, '0, 1'b1);
      check_eq("mul_not_early", out_valid, 1'b0);
      drive_cycle(1'b0, 4'b0000, '0, '0, 1'b1);
      check_eq("mul_valid", out_valid, 1'b1);
      check_eq("mul_val", output_val, 32'd42);
      check_eq("mul_flags", flags, 4'b0000);
      drive_cycle(1'b1, 4'b1100, 32'hFFFF_FFFF, 32'd2, 1'b1);
      repeat (W) drive_cycle(1'b0, 4'b0000, '0, '0, 1'b1);
      check_eq("mul_wrap_val", output_val, 32'hFFFF_FFFE);
      check_eq("mul_wrap_flags", flags, 4'b1000);
`else
      check_eq("mul_off_valid", out_valid, 1'b1);
      check_eq("mul_off_val", output_val, 32'h0);
      check_eq("mul_off_flags", flags, 4'b0100);
`endif

      // reset in the middle of a multiply
      drive_cycle(1'b1, 4'b1100, 32'd7, 32'd6, 1'b1);
      repeat (10) drive_cycle(1'b0, 4'b0000, '0, '0, 1'b1);
      apply_reset(2);
      drive_cycle(1'b1, 4'b0000, 32'd2, 32'd2, 1'b1);
      check_eq("post_rst_val", output_val, 32'd4);
      check_eq("post_rst_flags", flags, 4'b0000);

      repeat (600) begin
         drive_cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                     pick_operand(), pick_operand(), $urandom_range(0, 3) != 0);
      end
      repeat (W + 4) drive_cycle(1'b0, 4'b0000, '0, '0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
